apb_master_bridge: RTL and testbench

//   APB requester that drives the APB-to-I2C register interface from an internal command port.

---
 rtl/apb_master_bridge.sv | 158 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge
//  Summary  : Single-beat command port to APB requester (SETUP/ACCESS) with
//             bounded PREADY wait and registered response.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
   localparam int          CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic        TO_EN    = (TIMEOUT != 0);

   logic [1:0]        state_q,       state_d;
   logic              psel_q,        psel_d;
   logic              penable_q,     penable_d;
   logic              pwrite_q,      pwrite_d;
   logic [ADDR_W-1:0] paddr_q,       paddr_d;
   logic [DATA_W-1:0] pwdata_q,      pwdata_d;
   logic              rsp_valid_q,   rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
   logic              rsp_err_q,     rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]  cnt_q,         cnt_d;

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;

      case (state_q)
         IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = IDLE;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               // cnt_q counts completed wait cycles, so this is the TIMEOUT-th one.
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign PSELx       = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_bridge
//  Summary  : Directed self-checking bench for apb_master_bridge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_bridge;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              PCLK;
   logic              PRESETn;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              busy;
   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;
   logic              PSLVERR;

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_seen;
   logic [DATA_W-1:0] cfg_reg;

   apb_master_bridge #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .PSELx       (PSELx),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .PRDATA      (PRDATA),
      .PSLVERR     (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Completer CONFIG register at 0x8, updated on a completed write.
   always @(posedge PCLK) begin
      if (PRESETn && PSELx && PENABLE && PREADY && PWRITE && (PADDR == 32'h8))
         cfg_reg <= PWDATA;
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
   endtask

   initial begin
      cfg_reg   = '0;
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      PREADY    = 1'b0;
      PRDATA    = '0;
      PSLVERR   = 1'b0;
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy",      busy, 0);
      check("rst_psel",      PSELx, 0);
      check("rst_penable",   PENABLE, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_paddr",     PADDR, 0);
      tick(); tick();
      PRESETn = 1'b1;
      tick();

      // 1: zero-wait write
      issue(1'b1, 32'h8, 32'h0000_1234);
      PREADY = 1'b1;
      tick();                                   // c1
      cmd_valid = 1'b0;
      check("t1_c1_psel",    PSELx, 1);
      check("t1_c1_penable", PENABLE, 0);
      check("t1_c1_paddr",   PADDR, 32'h8);
      check("t1_c1_pwdata",  PWDATA, 32'h1234);
      check("t1_c1_pwrite",  PWRITE, 1);
      check("t1_c1_busy",    busy, 1);
      check("t1_c1_ready",   cmd_ready, 0);
      tick();                                   // c2
      check("t1_c2_penable", PENABLE, 1);
      check("t1_c2_rspv",    rsp_valid, 0);
      tick();                                   // c3
      check("t1_c3_rspv",    rsp_valid, 1);
      check("t1_c3_err",     rsp_err, 0);
      check("t1_c3_rdata",   rsp_rdata, 0);
      check("t1_c3_psel",    PSELx, 0);
      check("t1_c3_ready",   cmd_ready, 1);
      check("t1_cfg",        cfg_reg, 32'h1234);
      tick();
      check("t1_pulse_end",  rsp_valid, 0);

      // 2: zero-wait read
      issue(1'b0, 32'h4, 32'hFFFF_FFFF);
      PRDATA = 32'hA5A5_0001;
      tick(); cmd_valid = 1'b0;
      tick(); tick();                           // c3
      check("t2_rspv",  rsp_valid, 1);
      check("t2_rdata", rsp_rdata, 32'hA5A5_0001);
      check("t2_err",   rsp_err, 0);
      tick();

      // 3: write with three wait states; command fields change while busy
      issue(1'b1, 32'h0, 32'hDEAD_BEEF);
      PREADY = 1'b0;
      PRDATA = 32'h1111_2222;
      tick();                                   // c1
      cmd_valid = 1'b0;
      cmd_addr  = 32'h0000_0FF0;
      cmd_wdata = 32'h0BAD_0BAD;
      check("t3_c1_paddr",  PADDR, 32'h0);
      check("t3_c1_pwdata", PWDATA, 32'hDEAD_BEEF);
      tick(); tick(); tick(); tick();           // c5
      check("t3_c5_paddr",   PADDR, 32'h0);
      check("t3_c5_pwdata",  PWDATA, 32'hDEAD_BEEF);
      check("t3_c5_penable", PENABLE, 1);
      check("t3_c5_rspv",    rsp_valid, 0);
      PREADY = 1'b1;
      tick();                                   // c6
      check("t3_c6_rspv",  rsp_valid, 1);
      check("t3_c6_rdata", rsp_rdata, 0);
      check("t3_c6_err",   rsp_err, 0);
      tick();

      // 4: read that never completes -> timeout after TIMEOUT access cycles
      issue(1'b0, 32'h10, 32'h0);
      PREADY  = 1'b0;
      PSLVERR = 1'b1;
      PRDATA  = 32'hCAFE_F00D;
      tick(); cmd_valid = 1'b0;                 // c1
      tick();                                   // c2
      rsp_seen = 0;
      for (int c = 2; c <= 17; c++) begin
         if (rsp_valid || !PENABLE) rsp_seen++;
         tick();
      end
      check("t4_wait_cycles_clean", rsp_seen, 0);
      check("t4_rspv",    rsp_valid, 1);
      check("t4_err",     rsp_err, 1);
      check("t4_timeout", rsp_timeout, 1);
      check("t4_rdata",   rsp_rdata, 0);
      check("t4_psel",    PSELx, 0);
      check("t4_penable", PENABLE, 0);
      tick();
      check("t4_hold_rspv",    rsp_valid, 0);
      check("t4_hold_timeout", rsp_timeout, 1);
      check("t4_hold_err",     rsp_err, 1);

      // 5: slave error, then back-to-back command accepted on the response cycle
      issue(1'b1, 32'hC, 32'h0000_00C0);
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      tick(); cmd_valid = 1'b0;
      tick(); tick();                           // c3
      check("t5_rspv",    rsp_valid, 1);
      check("t5_err",     rsp_err, 1);
      check("t5_timeout", rsp_timeout, 0);
      check("t5_ready",   cmd_ready, 1);
      issue(1'b0, 32'h4, 32'h0);
      PSLVERR = 1'b0;
      PRDATA  = 32'h0000_7777;
      tick();                                   // next command c1
      cmd_valid = 1'b0;
      check("t5b_psel",     PSELx, 1);
      check("t5b_paddr",    PADDR, 32'h4);
      check("t5b_err_hold", rsp_err, 1);
      tick(); tick();
      check("t5b_rspv",  rsp_valid, 1);
      check("t5b_rdata", rsp_rdata, 32'h0000_7777);
      check("t5b_err",   rsp_err, 0);
      tick();

      // 6: reset asserted during ACCESS
      issue(1'b1, 32'h8, 32'h0000_5555);
      PREADY = 1'b0;
      tick(); cmd_valid = 1'b0;
      tick();                                   // c2
      check("t6_penable_pre", PENABLE, 1);
      #2;
      PRESETn = 1'b0;
      #1;
      check("t6_psel_async",    PSELx, 0);
      check("t6_penable_async", PENABLE, 0);
      check("t6_ready_async",   cmd_ready, 1);
      PREADY = 1'b1;
      tick();
      PRESETn = 1'b1;
      rsp_seen = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (rsp_valid) rsp_seen++;
      end
      check("t6_no_rsp", rsp_seen, 0);
      check("t6_ready",  cmd_ready, 1);
      check("t6_busy",   busy, 0);
      check("t6_cfg",    cfg_reg, 32'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
